alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter CTRL_W, default 3, ALU control code width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  2  per-requester operation request (bit 0 = requester 0).
REQ-006 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-007 SHALL have port req_a  input  2*DATA_W  per-requester operand a (requester 0 in low half).
REQ-008 SHALL have port req_b  input  2*DATA_W  per-requester operand b.
REQ-009 SHALL have port req_ctrl  input  2*CTRL_W  per-requester ALU control code.
REQ-010 SHALL have port rsp_valid  output  2  per-requester result available.
REQ-011 SHALL have port rsp_ready  input  2  per-requester result consumed.
REQ-012 SHALL have port rsp_result  output  DATA_W  registered ALU result, shared by both requesters.
REQ-013 SHALL have port rsp_zero  output  1  registered zero flag (result == 0).
REQ-014 SHALL have port rsp_err  output  1  control code was not add/sub/and/or/slt.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-016 IDLE: if any req_valid, grant one requester, assert its req_ready for that cycle only, latch its a/b/ctrl, go to EXEC.
REQ-017 req_ready SHALL be combinational from state==IDLE, req_valid and the priority pointer; never asserted outside IDLE.
REQ-018 Arbitration SHALL be round-robin: pointer names the preferred requester; the sole valid requester always wins; if both valid, the pointer's requester wins.
REQ-019 Pointer SHALL move to the non-granted requester on every grant.
REQ-020 EXEC: drive latched operands into the ALU, register result, zero and err, go to RESP; latency request-accept to rsp_valid = 2 cycles.
REQ-021 RESP: assert rsp_valid only on the granted requester's bit; hold result/zero/err stable until that requester's rsp_ready is 1; then return to IDLE.
REQ-022 rsp_ready on the non-granted bit SHALL be ignored.
REQ-023 Control codes: add 010, sub 110, and 000, or 001, slt 111 (signed compare); any other code SHALL give result 0, zero 1, err 1.
REQ-024 Add/sub SHALL wrap modulo 2^DATA_W; no overflow flag.
REQ-025 A request withdrawn (req_valid dropped) before grant SHALL be ignored; a granted request SHALL complete regardless of later req_valid.
REQ-026 Earliest re-grant SHALL be the cycle after the RESP handshake (3-cycle minimum per operation).

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, pointer to requester 0, rsp_valid 00, rsp_result 0, rsp_zero 0, rsp_err 0.
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-029 Release of rst_n SHALL take effect on the next rising clk edge; req_ready 00 while rst_n low.

Structure
REQ-030 ALU control code constants (ADD, SUB, AND, OR, SLT) and FSM state encoding SHALL live in a shared package used by alu_control, alu and alu_arbiter.
REQ-031 The existing alu module SHALL be instanced once as the sole sub-module; arbiter logic SHALL not duplicate ALU arithmetic except the illegal-code override.

Verification
REQ-032 Req0 only, a=5, b=3, ctrl=010 -> req_ready=01 in cycle 0, rsp_valid=01 in cycle 2, result 8, zero 0, err 0.
REQ-033 Both valid continuously after reset, ctrl=110, a=b=7 -> grants alternate 0,1,0,1; each response result 0, zero 1.
REQ-034 Req1 ctrl=111, a=0xFFFFFFFF, b=1 -> result 1; swapped operands -> result 0.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and result stable, no new req_ready while req_valid=11.
REQ-036 ctrl=011 -> result 0, zero 1, err 1; rst_n pulsed low during EXEC -> no rsp_valid, pointer back to 0, next grant to requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU control codes and arbiter FSM encoding
package alu_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational add/sub/and/or/signed-slt unit, zero for unknown codes
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] y
);
  // select the operation result by control code
  always_comb
    y = ctrl == CTRL_W'(ALU_ADD) ? a + b :
        ctrl == CTRL_W'(ALU_SUB) ? a - b :
        ctrl == CTRL_W'(ALU_AND) ? a & b :
        ctrl == CTRL_W'(ALU_OR)  ? a | b :
        ctrl == CTRL_W'(ALU_SLT) ? DATA_W'($signed(a) < $signed(b)) : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end sharing one ALU
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [2*CTRL_W-1:0]   req_ctrl,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err
);
  state_e              state_q, state_d;
  logic                ptr_q, ptr_d, sel_q, sel_d, grant, bad;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, alu_y;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                zero_q, zero_d, err_q, err_d;

  alu #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_alu (.a(a_q), .b(b_q), .ctrl(ctrl_q), .y(alu_y));

  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

  // arbitration, handshakes and next-state for the single in-flight operation
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    res_d     = res_q;
    zero_d    = zero_q;
    err_d     = err_q;
    grant     = (&req_valid) ? ptr_q : req_valid[1];
    bad       = !(ctrl_q inside {CTRL_W'(ALU_ADD), CTRL_W'(ALU_SUB), CTRL_W'(ALU_AND),
                                 CTRL_W'(ALU_OR), CTRL_W'(ALU_SLT)});
    req_ready = (rst_n && state_q == S_IDLE && |req_valid) ? 2'b01 << grant : 2'b00;
    rsp_valid = state_q == S_RESP ? 2'b01 << sel_q : 2'b00;
    case (state_q)
      S_IDLE: if (|req_valid) begin
        state_d = S_EXEC;
        sel_d   = grant;
        ptr_d   = !grant;
        a_d     = grant ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        b_d     = grant ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        ctrl_d  = grant ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
      end
      S_EXEC: begin
        state_d = S_RESP;
        res_d   = bad ? '0 : alu_y;
        zero_d  = ~|res_d;
        err_d   = bad;
      end
      S_RESP: if (rsp_ready[sel_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks against a transaction-level model
module tb_alu_arbiter;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00, rsp_ready = 2'b11, req_ready, rsp_valid;
  logic [2*W-1:0] req_a = '0, req_b = '0;
  logic [5:0] req_ctrl = '0;
  logic [W-1:0] rsp_result;
  logic rsp_zero, rsp_err;
  int passed = 0, total = 0;

  alu_arbiter dut (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
                   .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .rsp_valid(rsp_valid),
                   .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
                   .rsp_err(rsp_err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  function automatic logic pick(input logic [1:0] v, input logic p);
    return (&v) ? p : v[1];
  endfunction

  function automatic logic [2:0] code_of(input logic g);
    return g ? req_ctrl[5:3] : req_ctrl[2:0];
  endfunction

  function automatic logic [W-1:0] ref_op(input logic g);
    logic [W-1:0] a, b;
    a = g ? req_a[63:32] : req_a[31:0];
    b = g ? req_b[63:32] : req_b[31:0];
    case (code_of(g))
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

  logic m_busy, m_resp, m_owner, m_ptr, m_err;
  logic [W-1:0] m_res;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 0; m_resp <= 0; m_owner <= 0; m_ptr <= 0; m_res <= '0; m_err <= 0;
    end else if (!m_busy) begin
      if (|req_valid) begin
        m_busy  <= 1;
        m_owner <= pick(req_valid, m_ptr);
        m_ptr   <= !pick(req_valid, m_ptr);
        m_res   <= ref_op(pick(req_valid, m_ptr));
        m_err   <= !(code_of(pick(req_valid, m_ptr)) inside {3'b010, 3'b110, 3'b000, 3'b001, 3'b111});
      end
    end else if (!m_resp) m_resp <= 1;
    else if (rsp_ready[m_owner]) begin
      m_busy <= 0; m_resp <= 0;
    end

  always @(negedge clk) begin
    chk("req_ready", req_ready, (rst_n && !m_busy && |req_valid) ? 2'b01 << pick(req_valid, m_ptr) : 2'b00);
    chk("rsp_valid", rsp_valid, (m_busy && m_resp) ? 2'b01 << m_owner : 2'b00);
    if (m_busy && m_resp) begin
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", rsp_zero, m_res == 0);
      chk("rsp_err", rsp_err, m_err);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    rst_n = 0; step(); rst_n = 1;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int n = 0; n < 20 && g == 2'b00; n++) begin
      @(negedge clk);
      g = req_ready;
    end
    chk("grant_seen", |g, 1'b1);
  endtask

  task automatic wait_rsp();
    logic seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = |rsp_valid;
    end
    chk("rsp_seen", seen, 1'b1);
  endtask

  task automatic do_op(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] c, output logic [W-1:0] res, output logic z, output logic e);
    logic [1:0] g;
    req_valid = idx ? 2'b10 : 2'b01;
    req_a = idx ? {a, 32'd0} : {32'd0, a};
    req_b = idx ? {b, 32'd0} : {32'd0, b};
    req_ctrl = idx ? {c, 3'd0} : {3'd0, c};
    wait_grant(g);
    chk("op_grant", g, idx ? 2'b10 : 2'b01);
    step();
    req_valid = 2'b00;
    wait_rsp();
    res = rsp_result; z = rsp_zero; e = rsp_err;
    step();
  endtask

  initial begin
    logic [W-1:0] r, held;
    logic z, e;
    logic [1:0] g, hv;
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero", rsp_zero, 1'b0);
    chk("rst_err", rsp_err, 1'b0);
    step();
    rst_n = 1; req_valid = 2'b01;
    req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd3}; req_ctrl = {3'd0, 3'b010};
    @(negedge clk); chk("add_ready_c0", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    @(negedge clk); chk("add_valid_c1", rsp_valid, 2'b00);
    @(negedge clk); chk("add_valid_c2", rsp_valid, 2'b01);
    chk("add_result", rsp_result, 32'd8);
    chk("add_zero", rsp_zero, 1'b0);
    chk("add_err", rsp_err, 1'b0);
    step();
    rst_pulse();
    req_valid = 2'b11; req_a = {32'd7, 32'd7}; req_b = {32'd7, 32'd7}; req_ctrl = {3'b110, 3'b110};
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      chk("rr_grant", g, k % 2 ? 2'b10 : 2'b01);
      wait_rsp();
      chk("rr_result", rsp_result, 32'd0);
      chk("rr_zero", rsp_zero, 1'b1);
    end
    step(); req_valid = 2'b00;
    do_op(1, 32'hFFFF_FFFF, 32'd1, 3'b111, r, z, e);
    chk("slt_neg", r, 32'd1);
    do_op(1, 32'd1, 32'hFFFF_FFFF, 3'b111, r, z, e);
    chk("slt_pos", r, 32'd0);
    rsp_ready = 2'b00; req_valid = 2'b11;
    req_a = {32'd4, 32'd9}; req_b = {32'd1, 32'd2}; req_ctrl = {3'b010, 3'b010};
    wait_rsp();
    held = rsp_result; hv = rsp_valid;
    chk("hold_result", held, 32'd11);
    chk("hold_owner", hv, 2'b01);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, hv);
      chk("hold_stable", rsp_result, held);
      chk("hold_no_ready", req_ready, 2'b00);
    end
    step(); rsp_ready = 2'b11;
    step(); req_valid = 2'b00;
    do_op(0, 32'd5, 32'd5, 3'b011, r, z, e);
    chk("bad_result", r, 32'd0);
    chk("bad_zero", z, 1'b1);
    chk("bad_err", e, 1'b1);
    req_valid = 2'b10; req_ctrl = {3'b010, 3'b010};
    wait_grant(g);
    step(); req_valid = 2'b00; rst_n = 0;
    @(negedge clk); chk("rst_exec_valid", rsp_valid, 2'b00);
    step(); rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_exec_no_rsp", rsp_valid, 2'b00);
    end
    step(); req_valid = 2'b11;
    @(negedge clk); chk("rst_ptr_grant", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    repeat (4) step();
    repeat (3000) begin
      step();
      rst_n = $urandom_range(0, 199) != 0;
      req_valid = 2'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0 ? 2'b11 : 2'($urandom);
      req_a = $urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      req_b = $urandom_range(0, 3) == 0 ? req_a : {$urandom, $urandom};
      req_ctrl = 6'($urandom);
    end
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
